// File: rtl/sqrt_pkg.sv
// Shared types and default sizing for the vector sqrt issue block.
package sqrt_pkg;

    localparam int NUM_ELEM_DEF        = 8;
    localparam int MAX_OUTSTANDING_DEF = 4;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sqrt_issue_state_t;

endpackage

// File: rtl/sqrt_vec_issue.sv
// Streams a vector of FP16 operands through an external sqrt_fp16 unit and gathers the results in order.
// Optional SQRT_ISSUE_MASK_EN adds vec_mask: masked-off elements bypass the unit and pass their operand through.
module sqrt_vec_issue
    import sqrt_pkg::*;
#(
    parameter int NUM_ELEM        = NUM_ELEM_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  fp16_t [NUM_ELEM-1:0]       vec_operand,
`ifdef SQRT_ISSUE_MASK_EN
    input  logic [NUM_ELEM-1:0]        vec_mask,
`endif
    input  logic                       vec_valid_in,
    output logic                       vec_ready_in,
    output fp16_t [NUM_ELEM-1:0]       vec_result,
    output logic                       vec_valid_out,
    input  logic                       vec_ready_out,
    output fp16_t                      sq_operand,
    output logic                       sq_valid_in,
    output logic                       sq_ready_out,
    input  logic                       sq_ready_in,
    input  logic                       sq_valid_out,
    input  fp16_t                      sq_result,
    output logic                       err_out
);

    localparam int PW = $clog2(NUM_ELEM + 1);
    localparam int IW = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t PTR_END = ptr_t'(NUM_ELEM);

    sqrt_issue_state_t     state_q;
    fp16_t [NUM_ELEM-1:0]  op_q, res_q;
    ptr_t                  iss_ptr_q, ret_ptr_q, iss_ptr_d, ret_ptr_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic                  err_q;
    logic                  issue, retire, in_run;
    logic [NUM_ELEM-1:0]   in_mask, act_mask;

`ifdef SQRT_ISSUE_MASK_EN
    logic [NUM_ELEM-1:0]   mask_q;
    assign in_mask  = vec_mask;
    assign act_mask = mask_q;
`else
    assign in_mask  = '1;
    assign act_mask = '1;
`endif

    // Pointers always rest on an active element (or PTR_END), so masked slots cost no cycles.
    function automatic ptr_t next_act(input logic [NUM_ELEM-1:0] m, input ptr_t from);
        next_act = PTR_END;
        for (int i = NUM_ELEM - 1; i >= 0; i--)
            if (m[i] && ptr_t'(i) >= from) next_act = ptr_t'(i);
    endfunction

    assign in_run       = (state_q == RUN);
    assign sq_valid_in  = in_run && (iss_ptr_q < PTR_END) && (outst_q < CW'(MAX_OUTSTANDING));
    assign sq_ready_out = in_run && (outst_q != '0);
    assign sq_operand   = (in_run && iss_ptr_q < PTR_END) ? op_q[iss_ptr_q[IW-1:0]] : '0;
    assign issue        = sq_valid_in && sq_ready_in;
    assign retire       = sq_valid_out && sq_ready_out;

    assign iss_ptr_d = issue  ? next_act(act_mask, ptr_t'(iss_ptr_q + 1'b1)) : iss_ptr_q;
    assign ret_ptr_d = retire ? next_act(act_mask, ptr_t'(ret_ptr_q + 1'b1)) : ret_ptr_q;
    assign outst_d   = outst_q + CW'(issue) - CW'(retire);

    assign vec_ready_in  = (state_q == IDLE);
    assign vec_valid_out = (state_q == DONE);
    assign vec_result    = res_q;
    assign err_out       = err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            op_q      <= '0;
            res_q     <= '0;
            iss_ptr_q <= '0;
            ret_ptr_q <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
`ifdef SQRT_ISSUE_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            // A result the block is not waiting for is dropped and flagged.
            if (sq_valid_out && !sq_ready_out) err_q <= 1'b1;
            case (state_q)
                IDLE: if (vec_valid_in) begin
                    op_q <= vec_operand;
                    for (int i = 0; i < NUM_ELEM; i++)
                        res_q[i] <= in_mask[i] ? fp16_t'('0) : vec_operand[i];
                    iss_ptr_q <= next_act(in_mask, '0);
                    ret_ptr_q <= next_act(in_mask, '0);
                    outst_q   <= '0;
`ifdef SQRT_ISSUE_MASK_EN
                    mask_q    <= vec_mask;
`endif
                    state_q   <= RUN;
                end
                RUN: begin
                    iss_ptr_q <= iss_ptr_d;
                    ret_ptr_q <= ret_ptr_d;
                    outst_q   <= outst_d;
                    if (retire) res_q[ret_ptr_q[IW-1:0]] <= sq_result;
                    if (ret_ptr_d == PTR_END) state_q <= DONE;
                end
                DONE: if (vec_ready_out) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_vec_issue.sv
// Scoreboard bench for sqrt_vec_issue: a behavioural sqrt unit with variable latency plus an in-order vector model.
module tb_sqrt_vec_issue;

    localparam int NE = 8;
    localparam int MO = 4;
    localparam int VW = NE * 16;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic [NE-1:0][15:0] vec_operand = '0;
    logic [NE-1:0][15:0] vec_result;
`ifdef SQRT_ISSUE_MASK_EN
    logic [NE-1:0] vec_mask = '1;
`endif
    logic          vec_valid_in = 1'b0;
    logic          vec_ready_in, vec_valid_out;
    logic          vec_ready_out = 1'b0;
    logic [15:0]   sq_operand;
    logic          sq_valid_in, sq_ready_out, err_out;
    logic          sq_ready_in = 1'b0;
    logic          sq_valid_out = 1'b0;
    logic [15:0]   sq_result = '0;

    sqrt_vec_issue #(.NUM_ELEM(NE), .MAX_OUTSTANDING(MO)) dut (
        .CLK(CLK), .nRST(nRST),
        .vec_operand(vec_operand),
`ifdef SQRT_ISSUE_MASK_EN
        .vec_mask(vec_mask),
`endif
        .vec_valid_in(vec_valid_in), .vec_ready_in(vec_ready_in),
        .vec_result(vec_result), .vec_valid_out(vec_valid_out), .vec_ready_out(vec_ready_out),
        .sq_operand(sq_operand), .sq_valid_in(sq_valid_in), .sq_ready_out(sq_ready_out),
        .sq_ready_in(sq_ready_in), .sq_valid_out(sq_valid_out), .sq_result(sq_result),
        .err_out(err_out)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    logic [VW-1:0] sb_q[$];
    logic [15:0]   exp_ops[$];
    logic [15:0]   pend_val[$];
    int            pend_due[$];
    int  cyc = 0, outst_m = 0, max_outst = 0, n_iss = 0, n_ret = 0, n_vout = 0;
    int  lat_min = 1, lat_max = 1, rdy_pct = 100, vro_pct = 100;
    bit  rdy_hold = 0, vro_hold = 0, spur = 0;
    bit  prev_done = 0;
    logic [VW-1:0] prev_res = '0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Ideal sqrt: exact for the directed values, exponent-halving estimate elsewhere.
    function automatic logic [15:0] sqm(input logic [15:0] x);
        case (x)
            16'h0000: return 16'h0000;
            16'h3C00: return 16'h3C00;
            16'h4400: return 16'h4000;
            16'h4C00: return 16'h4400;
            16'h4880: return 16'h4200;
            default:  return (x >> 1) + 16'h1E00;
        endcase
    endfunction

    // sqrt-unit model and monitor: drive at negedge, observe the settled handshake 1 time unit later.
    always @(negedge CLK) begin
        bit was_spur;
        cyc++;
        was_spur = 0;
        sq_ready_in   = !rdy_hold && ($urandom_range(99) < rdy_pct);
        vec_ready_out = !vro_hold && ($urandom_range(99) < vro_pct);
        if (spur) begin
            sq_valid_out = 1'b1; sq_result = 16'hDEAD; spur = 0; was_spur = 1;
        end else if (pend_val.size() > 0 && pend_due[0] <= cyc) begin
            sq_valid_out = 1'b1; sq_result = pend_val[0];
        end else begin
            sq_valid_out = 1'b0; sq_result = 16'($urandom);
        end
        #1;
        if (nRST) begin
            if (was_spur) chk("spur_not_accepted", VW'(sq_ready_out), VW'(0));
            if (!vec_ready_in && !vec_valid_out) begin
                chk("run_sq_valid_in", VW'(sq_valid_in), VW'(exp_ops.size() > 0 && outst_m < MO));
                chk("run_sq_ready_out", VW'(sq_ready_out), VW'(outst_m > 0));
            end
            if (outst_m >= MO) chk("full_valid_low", VW'(sq_valid_in), VW'(0));
            if (sq_valid_in && sq_ready_in) begin
                n_iss++;
                if (exp_ops.size() == 0) chk("unexpected_issue", VW'(1), VW'(0));
                else chk("issue_operand", VW'(sq_operand), VW'(exp_ops.pop_front()));
                pend_val.push_back(sqm(sq_operand));
                pend_due.push_back(cyc + $urandom_range(lat_max, lat_min));
                outst_m++;
            end
            if (sq_valid_out && sq_ready_out && !was_spur) begin
                n_ret++;
                void'(pend_val.pop_front());
                void'(pend_due.pop_front());
                outst_m--;
            end
            if (outst_m > max_outst) max_outst = outst_m;
            if (vec_valid_out) begin
                if (prev_done) chk("done_result_stable", vec_result, prev_res);
                chk("done_ready_in_low", VW'(vec_ready_in), VW'(0));
                prev_done = !vec_ready_out;
                prev_res  = vec_result;
            end else prev_done = 0;
            if (vec_valid_out && vec_ready_out) begin
                n_vout++;
                if (sb_q.size() == 0) chk("unexpected_vec_out", VW'(1), VW'(0));
                else chk("vec_result", vec_result, sb_q.pop_front());
            end
        end
    end

    task automatic send(input logic [VW-1:0] ops, input logic [NE-1:0] m);
        logic [VW-1:0] exp;
        int t;
`ifndef SQRT_ISSUE_MASK_EN
        m = '1;
`else
        vec_mask = m;
`endif
        @(negedge CLK);
        vec_operand  = ops;
        vec_valid_in = 1'b1;
        #1;
        t = 0;
        while (!vec_ready_in && t < 500) begin @(negedge CLK); #1; t++; end
        if (!vec_ready_in) begin
            chk("send_timeout", VW'(0), VW'(1));
            vec_valid_in = 1'b0;
            return;
        end
        for (int i = 0; i < NE; i++) begin
            if (m[i]) begin
                exp[i*16 +: 16] = sqm(ops[i*16 +: 16]);
                exp_ops.push_back(ops[i*16 +: 16]);
            end else exp[i*16 +: 16] = ops[i*16 +: 16];
        end
        sb_q.push_back(exp);
        @(negedge CLK);
        vec_valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge CLK); #2; t++; end
        while (!(sb_q.size() == 0 && vec_ready_in) && t < 3000);
        if (!(sb_q.size() == 0 && vec_ready_in)) chk("drain_timeout", VW'(0), VW'(1));
    endtask

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] v;
        for (int i = 0; i < NE; i++) v[i*16 +: 16] = 16'($urandom_range(16'h7BFF));
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vec_valid_out"}, VW'(vec_valid_out), VW'(0));
        chk({tag, "_vec_ready_in"},  VW'(vec_ready_in),  VW'(1));
        chk({tag, "_vec_result"},    vec_result,         VW'(0));
        chk({tag, "_sq_valid_in"},   VW'(sq_valid_in),   VW'(0));
        chk({tag, "_sq_ready_out"},  VW'(sq_ready_out),  VW'(0));
        chk({tag, "_sq_operand"},    VW'(sq_operand),    VW'(0));
        chk({tag, "_err_out"},       VW'(err_out),       VW'(0));
    endtask

    initial begin
        logic [VW-1:0] v;
        int i0, r0, vo0;
        repeat (2) @(negedge CLK);
        #3 check_reset_outputs("reset");
        nRST = 1'b1;

        // Directed vector with an ideal unit: one output vector, exact results.
        v = '0;
        v[15:0] = 16'h4400; v[31:16] = 16'h3C00; v[47:32] = 16'h4C00; v[63:48] = 16'h4880;
        vo0 = n_vout;
        send(v, '1);
        wait_idle();
        chk("directed_single_out", VW'(n_vout - vo0), VW'(1));

        // Unit not ready for the first cycles of RUN.
        rdy_hold = 1;
        send(rvec(), '1);
        i0 = n_iss; r0 = n_ret;
        repeat (5) @(negedge CLK);
        #2;
        chk("hold_no_issue", VW'(n_iss - i0), VW'(0));
        chk("hold_no_retire", VW'(n_ret - r0), VW'(0));
        rdy_hold = 0;
        wait_idle();

        // Long latency fills the outstanding window.
        lat_min = 6; lat_max = 6; max_outst = 0;
        send(rvec(), '1);
        wait_idle();
        chk("max_outstanding", VW'(max_outst), VW'(MO));

        // Consumer stalls in DONE.
        lat_min = 1; lat_max = 3; vro_hold = 1;
        send(rvec(), '1);
        begin
            int t = 0;
            while (!vec_valid_out && t < 200) begin @(negedge CLK); #2; t++; end
            chk("reach_done", VW'(vec_valid_out), VW'(1));
        end
        repeat (10) @(negedge CLK);
        vro_hold = 0;
        wait_idle();

`ifdef SQRT_ISSUE_MASK_EN
        i0 = n_iss;
        send(rvec(), 8'h0F);
        wait_idle();
        chk("mask_0f_issues", VW'(n_iss - i0), VW'(4));
        i0 = n_iss;
        send(rvec(), 8'h00);
        wait_idle();
        chk("mask_zero_issues", VW'(n_iss - i0), VW'(0));
`endif

        // Randomized traffic on both handshakes.
        lat_min = 1; lat_max = 8; rdy_pct = 70; vro_pct = 70;
        for (int k = 0; k < 20; k++) send(rvec(), NE'($urandom));
        wait_idle();
        rdy_pct = 100; vro_pct = 100;

        // Stray result while idle sets the sticky error.
        chk("err_clear_before_spur", VW'(err_out), VW'(0));
        #3 spur = 1;
        repeat (2) @(negedge CLK);
        #2 chk("err_set_idle_spur", VW'(err_out), VW'(1));
        send(rvec(), '1);
        wait_idle();
        chk("err_sticky", VW'(err_out), VW'(1));

        // Reset in the middle of RUN.
        lat_min = 6; lat_max = 6;
        send(rvec(), '1);
        repeat (3) @(negedge CLK);
        #3 nRST = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        sb_q.delete(); exp_ops.delete(); pend_val.delete(); pend_due.delete();
        outst_m = 0;
        @(negedge CLK);
        #3 nRST = 1'b1;
        spur = 1;
        repeat (2) @(negedge CLK);
        #2 chk("err_late_result_after_reset", VW'(err_out), VW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
